// File: rtl/hdmi_qsys_pio_gen_if.sv
// rtl/hdmi_qsys_pio_gen_if.sv - Avalon-MM slave bus bundle for the PIO block
// Word-addressed, zero-wait-state register port; readdata is combinational.
interface hdmi_qsys_pio_gen_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/hdmi_qsys_pio_gen.sv
// rtl/hdmi_qsys_pio_gen.sv - parametrised Avalon-MM GPIO with edge capture and irq
// Optional OUTSET/OUTCLR registers at addresses 4/5 under macro HDMI_QSYS_PIO_BITSET_EN.
module hdmi_qsys_pio_gen #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  hdmi_qsys_pio_gen_if.slave   bus,
  input  logic [WIDTH-1:0]     pio_in,
  output logic [WIDTH-1:0]     pio_out,
  output logic [WIDTH-1:0]     pio_oe,
  output logic                 irq
);

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_DIR  = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
`ifdef HDMI_QSYS_PIO_BITSET_EN
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;
`endif

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] data_nxt;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] in_prev;
  logic [WIDTH-1:0] detect;
  logic [WIDTH-1:0] wd;
  logic [31:0]      rd_word;
  logic             wr;
  logic             unused_bits;

  assign wr          = bus.chipselect & ~bus.write_n;
  assign wd          = bus.writedata[WIDTH-1:0];
  assign unused_bits = ^bus.writedata;
  assign in_sync     = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      in_prev <= '0;
    end else begin
      sync_q[0] <= pio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      in_prev <= in_sync;
    end
  end

  // Edge detection runs on every bit, outputs included, so software can
  // observe its own output transitions when the pin is looped back.
  always_comb begin
    if (EDGE_TYPE == 0)
      detect = in_sync & ~in_prev;
    else if (EDGE_TYPE == 1)
      detect = ~in_sync & in_prev;
    else
      detect = in_sync ^ in_prev;
  end

  always_comb begin
    data_nxt = data_out;
    if (wr && bus.address == ADDR_DATA)
      data_nxt = wd;
`ifdef HDMI_QSYS_PIO_BITSET_EN
    else if (wr && bus.address == ADDR_SET)
      data_nxt = data_out | wd;
    else if (wr && bus.address == ADDR_CLR)
      data_nxt = data_out & ~wd;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE;
      dir      <= DIR_RESET;
      mask     <= '0;
    end else begin
      data_out <= data_nxt;
      if (wr && bus.address == ADDR_DIR)  dir  <= wd;
      if (wr && bus.address == ADDR_MASK) mask <= wd;
    end
  end

  // A fresh edge in the same cycle as a clear must not be lost: set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
    end else if (wr && bus.address == ADDR_EDGE) begin
      edge_cap <= (edge_cap & ~wd) | detect;
    end else begin
      edge_cap <= edge_cap | detect;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= |(edge_cap & mask);
  end

  always_comb begin
    rd_word = '0;
    case (bus.address)
      ADDR_DATA: rd_word[WIDTH-1:0] = (dir & data_out) | (~dir & in_sync);
      ADDR_DIR:  rd_word[WIDTH-1:0] = dir;
      ADDR_MASK: rd_word[WIDTH-1:0] = mask;
      ADDR_EDGE: rd_word[WIDTH-1:0] = edge_cap;
      default:   rd_word = '0;
    endcase
  end

  assign bus.readdata = rd_word;
  assign pio_out      = data_out;
  assign pio_oe       = dir;

endmodule

// File: tb/tb_hdmi_qsys_pio_gen.sv
// tb/tb_hdmi_qsys_pio_gen.sv - self-checking bench for hdmi_qsys_pio_gen
// Register-level stimulus plus a history-based reference model for edge capture.
module tb_hdmi_qsys_pio_gen;

`ifdef HDMI_QSYS_PIO_BITSET_EN
  localparam bit BITSET = 1'b1;
`else
  localparam bit BITSET = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] pio_in = 8'h00;
  logic [7:0] pio_out;
  logic [7:0] pio_oe;
  logic       irq;
  int         n_checks = 0;
  int         n_fail = 0;

  hdmi_qsys_pio_gen_if bus ();

  hdmi_qsys_pio_gen #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .DIR_RESET(8'h00), .EDGE_TYPE(0), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .pio_in(pio_in), .pio_out(pio_out), .pio_oe(pio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    tick();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic quiet_clear;
    pio_in = 8'h00;
    bus_write(3'd1, 32'h0);
    bus_write(3'd2, 32'h0);
    repeat (3) tick();
    bus_write(3'd3, 32'hFF);
    tick();
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    reset_n = 1'b0; pio_in = 8'h00;
    repeat (2) tick();
    n_checks++; if (pio_out !== 8'hA5) begin n_fail++; $display("FAIL reset_pio_out got %h want a5", pio_out); end
    n_checks++; if (pio_oe !== 8'h00) begin n_fail++; $display("FAIL reset_pio_oe got %h want 00", pio_oe); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
    reset_n = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_read addr %0d got %h want 0", a, rd); end
    end
    pio_in = 8'h5A;
    tick();
    bus_read(3'd0, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL sync_depth_1 got %h want 0", rd); end
    tick();
    bus_read(3'd0, rd);
    n_checks++; if (rd !== 32'h5A) begin n_fail++; $display("FAIL sync_depth_2 got %h want 5a", rd); end
  endtask

  task automatic test_data_dir;
    logic [31:0] rd;
    logic [7:0]  d, dr, v, m;
    pio_in = 8'hF0;
    bus_write(3'd1, 32'h0F);
    bus_write(3'd0, 32'h3C);
    n_checks++; if (pio_oe !== 8'h0F) begin n_fail++; $display("FAIL dir_oe got %h want 0f", pio_oe); end
    n_checks++; if (pio_out !== 8'h3C) begin n_fail++; $display("FAIL data_out got %h want 3c", pio_out); end
    bus_read(3'd0, rd);
    n_checks++; if (rd !== 32'hFC) begin n_fail++; $display("FAIL data_read got %h want fc", rd); end
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom); dr = 8'($urandom); v = 8'($urandom); m = 8'($urandom);
      pio_in = v;
      bus_write(3'd1, {$urandom, dr});
      bus_write(3'd0, {24'hABCDEF, d});
      bus_write(3'd2, {24'h0, m});
      bus_write(3'd6, 32'hFFFF_FFFF);
      bus_write(3'd7, 32'hFFFF_FFFF);
      bus_read(3'd0, rd);
      n_checks++; if (rd !== {24'h0, (dr & d) | (~dr & v)}) begin n_fail++; $display("FAIL rand_data_read got %h want %h", rd, {24'h0, (dr & d) | (~dr & v)}); end
      bus_read(3'd1, rd);
      n_checks++; if (rd !== {24'h0, dr}) begin n_fail++; $display("FAIL rand_dir_read got %h want %h", rd, dr); end
      bus_read(3'd2, rd);
      n_checks++; if (rd !== {24'h0, m}) begin n_fail++; $display("FAIL rand_mask_read got %h want %h", rd, m); end
      bus_read(3'd6, rd);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL addr6_read got %h want 0", rd); end
      n_checks++; if (pio_out !== d || pio_oe !== dr) begin n_fail++; $display("FAIL rand_pins out %h oe %h want %h %h", pio_out, pio_oe, d, dr); end
    end
  endtask

  task automatic test_edge_latency;
    logic [31:0] rd;
    quiet_clear();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL lat_pre_irq got %b want 0", irq); end
    bus_write(3'd2, 32'h01);
    pio_in = 8'h01;
    for (int e = 1; e <= 4; e++) begin
      tick();
      bus_read(3'd3, rd);
      n_checks++; if (rd !== ((e >= 3) ? 32'h01 : 32'h00)) begin n_fail++; $display("FAIL lat_cap edge %0d got %h want %h", e, rd, (e >= 3) ? 1 : 0); end
      n_checks++; if (irq !== (e >= 4)) begin n_fail++; $display("FAIL lat_irq edge %0d got %b want %b", e, irq, e >= 4); end
    end
    bus_write(3'd3, 32'h01);
    bus_read(3'd3, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL clr_cap got %h want 0", rd); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL clr_irq_stage got %b want 1", irq); end
    tick();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL clr_irq got %b want 0", irq); end
  endtask

  task automatic test_set_wins;
    logic [31:0] rd;
    quiet_clear();
    pio_in = 8'h04;
    repeat (2) tick();
    bus_write(3'd3, 32'h04);
    bus_read(3'd3, rd);
    n_checks++; if (rd !== 32'h04) begin n_fail++; $display("FAIL set_wins got %h want 04", rd); end
    bus_write(3'd3, 32'h04);
    bus_read(3'd3, rd);
    n_checks++; if (rd !== 32'h00) begin n_fail++; $display("FAIL set_wins_clear got %h want 00", rd); end
  endtask

  task automatic test_bitset;
    logic [31:0] rd;
    logic [7:0]  exp;
    bus_write(3'd1, 32'hFF);
    bus_write(3'd0, 32'h0F);
    bus_write(3'd4, 32'h30);
    exp = BITSET ? 8'h3F : 8'h0F;
    n_checks++; if (pio_out !== exp) begin n_fail++; $display("FAIL outset got %h want %h", pio_out, exp); end
    bus_write(3'd5, 32'h03);
    exp = BITSET ? 8'h3C : 8'h0F;
    n_checks++; if (pio_out !== exp) begin n_fail++; $display("FAIL outclr got %h want %h", pio_out, exp); end
    bus_read(3'd0, rd);
    n_checks++; if (rd !== {24'h0, exp}) begin n_fail++; $display("FAIL bitset_read0 got %h want %h", rd, exp); end
    bus_read(3'd4, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL addr4_read got %h want 0", rd); end
    bus_read(3'd5, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL addr5_read got %h want 0", rd); end
  endtask

  // Model: an edge between values sampled at edges j-1 and j is captured at edge j+2.
  task automatic test_random_edges;
    logic [31:0] rd;
    logic [7:0]  hv [0:127];
    logic [7:0]  cap_m, mask_m, v, val, det;
    logic        irq_m;
    int          op, n;
    quiet_clear();
    cap_m = 8'h00; mask_m = 8'h00;
    hv[0] = 8'h00; hv[1] = 8'h00; hv[2] = 8'h00; n = 3;
    for (int i = 0; i < 80; i++) begin
      v = 8'($urandom); val = 8'($urandom); op = $urandom_range(0, 3);
      pio_in = v;
      bus.address = (op == 1) ? 3'd3 : 3'd2;
      bus.writedata = {24'h0, val};
      bus.chipselect = (op == 1 || op == 2);
      bus.write_n = !(op == 1 || op == 2);
      tick();
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
      hv[n] = v;
      det = hv[n-2] & ~hv[n-3];
      irq_m = |(cap_m & mask_m);
      cap_m = ((op == 1) ? (cap_m & ~val) : cap_m) | det;
      if (op == 2) mask_m = val;
      n_checks++; if (irq !== irq_m) begin n_fail++; $display("FAIL rnd_irq iter %0d got %b want %b", i, irq, irq_m); end
      bus_read(3'd3, rd);
      n_checks++; if (rd !== {24'h0, cap_m}) begin n_fail++; $display("FAIL rnd_cap iter %0d got %h want %h", i, rd, cap_m); end
      bus_read(3'd2, rd);
      n_checks++; if (rd !== {24'h0, mask_m}) begin n_fail++; $display("FAIL rnd_mask iter %0d got %h want %h", i, rd, mask_m); end
      bus_read(3'd0, rd);
      n_checks++; if (rd !== {24'h0, hv[n-1]}) begin n_fail++; $display("FAIL rnd_in iter %0d got %h want %h", i, rd, hv[n-1]); end
      n++;
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    quiet_clear();
    bus_write(3'd2, 32'h01);
    bus_write(3'd0, 32'h77);
    bus_write(3'd1, 32'h0F);
    pio_in = 8'h01;
    repeat (4) tick();
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL mid_pre_irq got %b want 1", irq); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_irq got %b want 0", irq); end
    n_checks++; if (pio_out !== 8'hA5 || pio_oe !== 8'h00) begin n_fail++; $display("FAIL mid_pins out %h oe %h want a5 00", pio_out, pio_oe); end
    bus_read(3'd2, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mid_mask got %h want 0", rd); end
    bus_read(3'd3, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mid_cap got %h want 0", rd); end
    bus_read(3'd0, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mid_sync got %h want 0", rd); end
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
    test_reset();
    test_data_dir();
    test_edge_latency();
    test_set_wins();
    test_bitset();
    test_random_edges();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
